// File: rtl/rotary_pkg.sv
// rotary_pkg
//   Shared definitions for the rotary encoder decoder: quadrature phase
//   encoding, sub-steps per detent, frequency width and the accumulator type.
package rotary_pkg;

    localparam int unsigned FREQ_W       = 2;
    localparam int unsigned DETENT_STEPS = 4;
    localparam int unsigned DEB_CNT_W    = 16;

    // Debounced {a,b} phase; clockwise order is 00 -> 01 -> 11 -> 10 -> 00.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_e;

    // Signed sub-step accumulator, only ever holds -4..+4.
    typedef logic signed [3:0] acc_t;

    function automatic phase_e phase_cw_next(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    function automatic phase_e phase_ccw_next(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rotary_debounce.sv
// rotary_debounce
//   Two-flop synchroniser followed by a stability debouncer for one encoder
//   channel. The debounced output follows the synchronised input only after
//   the two have differed on DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - raw channel input, asynchronous to clk
//   dout   - debounced, clk-synchronous channel value
module rotary_debounce
    import rotary_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 deb_q,   deb_d;
    logic [DEB_CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Counter runs only while the synchronised and debounced values
        // disagree; any agreement restarts the stability window.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/rotary_encoder_decoder.sv
// rotary_encoder_decoder
//   Decodes a mechanical quadrature rotary encoder into single-cycle detent
//   pulses and a 2-bit frequency select. Each channel is synchronised and
//   debounced; four legal quadrature sub-steps in one direction ending at
//   phase 00 form one detent.
//   Build option: define ROTARY_WRAP_EN to make frequency wrap (3->0, 0->3);
//   by default it saturates at 0 and 3.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enc_a      - raw encoder channel A
//   enc_b      - raw encoder channel B
//   frequency  - registered frequency select
//   step_cw    - one-cycle pulse per clockwise detent
//   step_ccw   - one-cycle pulse per counter-clockwise detent
module rotary_encoder_decoder
    import rotary_pkg::*;
#(
    parameter int unsigned          DEBOUNCE_CYCLES = 16,
    parameter logic [FREQ_W-1:0]    FREQ_RESET      = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_a,
    input  logic              enc_b,
    output logic [FREQ_W-1:0] frequency,
    output logic              step_cw,
    output logic              step_ccw
);

    localparam acc_t ACC_CW_FULL  = acc_t'(DETENT_STEPS);
    localparam acc_t ACC_CCW_FULL = -ACC_CW_FULL;

    logic deb_a;
    logic deb_b;

    phase_e            phase_cur;
    phase_e            phase_q,    phase_d;
    acc_t              acc_q,      acc_d;
    acc_t              acc_nxt;
    logic              legal;
    logic [FREQ_W-1:0] freq_q,     freq_d;
    logic              step_cw_q,  step_cw_d;
    logic              step_ccw_q, step_ccw_d;

    rotary_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enc_a),
        .dout  (deb_a)
    );

    rotary_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enc_b),
        .dout  (deb_b)
    );

    assign phase_cur = phase_e'({deb_a, deb_b});

    always_comb begin
        phase_d    = phase_cur;
        acc_d      = acc_q;
        acc_nxt    = acc_q;
        legal      = 1'b0;
        freq_d     = freq_q;
        step_cw_d  = 1'b0;
        step_ccw_d = 1'b0;

        // phase_q is the debounced phase one cycle ago, so transitions are
        // judged here and the resulting step lands one cycle after phase 00.
        if (phase_cur != phase_q) begin
            if (phase_cur == phase_cw_next(phase_q)) begin
                legal   = 1'b1;
                acc_nxt = acc_q + 4'sd1;
            end else if (phase_cur == phase_ccw_next(phase_q)) begin
                legal   = 1'b1;
                acc_nxt = acc_q - 4'sd1;
            end

            if (!legal) begin
                // Both channels moved at once: direction unknown, drop progress.
                acc_d = '0;
            end else if (phase_cur == PH_00) begin
                acc_d = '0;
                if (acc_nxt == ACC_CW_FULL) begin
                    step_cw_d = 1'b1;
                end else if (acc_nxt == ACC_CCW_FULL) begin
                    step_ccw_d = 1'b1;
                end
            end else begin
                acc_d = acc_nxt;
            end
        end

`ifdef ROTARY_WRAP_EN
        if (step_cw_d) begin
            freq_d = freq_q + 1'b1;
        end else if (step_ccw_d) begin
            freq_d = freq_q - 1'b1;
        end
`else
        if (step_cw_d && (freq_q != '1)) begin
            freq_d = freq_q + 1'b1;
        end else if (step_ccw_d && (freq_q != '0)) begin
            freq_d = freq_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_00;
            acc_q      <= '0;
            freq_q     <= FREQ_RESET;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            freq_q     <= freq_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
        end
    end

    assign frequency = freq_q;
    assign step_cw   = step_cw_q;
    assign step_ccw  = step_ccw_q;

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
module tb_rotary_encoder_decoder;

    localparam int unsigned DEB    = 4;
    localparam int unsigned LAT    = 2 + DEB + 1;
    localparam int unsigned SETTLE = 10;

    typedef struct {
        logic        cw;
        logic [1:0]  freq;
        int unsigned cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic [1:0] frequency;
    logic       step_cw;
    logic       step_ccw;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cyc;
    exp_t        sb_q[$];
    logic [1:0]  model_freq;
    logic [1:0]  prev_freq;
    logic        prev_rst_n;

    rotary_encoder_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .FREQ_RESET      (2'b00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .frequency (frequency),
        .step_cw   (step_cw),
        .step_ccw  (step_ccw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] model_cw(input logic [1:0] f);
`ifdef ROTARY_WRAP_EN
        return f + 2'd1;
`else
        return (f == 2'd3) ? 2'd3 : f + 2'd1;
`endif
    endfunction

    function automatic logic [1:0] model_ccw(input logic [1:0] f);
`ifdef ROTARY_WRAP_EN
        return f - 2'd1;
`else
        return (f == 2'd0) ? 2'd0 : f - 2'd1;
`endif
    endfunction

    // Scoreboard monitor: every step pulse must match the oldest expected
    // detent (direction, new frequency, exact cycle); otherwise frequency
    // must hold its value.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && prev_rst_n) begin
            if (step_cw && step_ccw) begin
                n_checks++;
                n_fail++;
                $display("FAIL both_steps: step_cw=%b step_ccw=%b, required not both", step_cw, step_ccw);
            end
            if (step_cw || step_ccw) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_step: cw=%b ccw=%b freq=%0d at cyc %0d, none expected", step_cw, step_ccw, frequency, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (step_cw !== e.cw || step_ccw !== !e.cw || frequency !== e.freq || cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL detent: got cw=%b ccw=%b freq=%0d cyc=%0d, required cw=%b freq=%0d cyc=%0d",
                                 step_cw, step_ccw, frequency, cyc, e.cw, e.freq, e.cyc);
                    end
                end
            end else begin
                n_checks++;
                if (frequency !== prev_freq) begin
                    n_fail++;
                    $display("FAIL freq_hold: freq=%0d, required %0d (no step)", frequency, prev_freq);
                end
            end
        end
        prev_freq  = frequency;
        prev_rst_n = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        sb_q.delete();
        model_freq = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic drive_phase(input logic [1:0] ph, input bit last, input bit cw);
        exp_t e;
        @(posedge clk);
        #1 {enc_a, enc_b} = ph;
        if (last) begin
            model_freq = cw ? model_cw(model_freq) : model_ccw(model_freq);
            e.cw   = cw;
            e.freq = model_freq;
            e.cyc  = cyc + LAT;
            sb_q.push_back(e);
        end
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d expected steps pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic cw_detent();
        drive_phase(2'b01, 1'b0, 1'b1);
        drive_phase(2'b11, 1'b0, 1'b1);
        drive_phase(2'b10, 1'b0, 1'b1);
        drive_phase(2'b00, 1'b1, 1'b1);
        wait_drain("cw_detent");
    endtask

    task automatic ccw_detent();
        drive_phase(2'b10, 1'b0, 1'b0);
        drive_phase(2'b11, 1'b0, 1'b0);
        drive_phase(2'b01, 1'b0, 1'b0);
        drive_phase(2'b00, 1'b1, 1'b0);
        wait_drain("ccw_detent");
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (frequency !== 2'b00 || step_cw !== 1'b0 || step_ccw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: freq=%0d cw=%b ccw=%b, required 0 0 0", frequency, step_cw, step_ccw);
        end
        n_checks++;
        if (dut.acc_q !== 4'sd0 || dut.phase_q !== rotary_pkg::PH_00) begin
            n_fail++;
            $display("FAIL reset_state: acc=%0d phase=%b, required 0 00", dut.acc_q, dut.phase_q);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_cw();
        cw_detent();
        n_checks++;
        if (frequency !== 2'd1) begin
            n_fail++;
            $display("FAIL single_cw_freq: freq=%0d, required 1", frequency);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] f0;
        f0 = model_freq;
        for (int w = 1; w <= 3; w++) begin
            @(posedge clk);
            #1 enc_a = 1'b1;
            repeat (w) @(posedge clk);
            #1 enc_a = 1'b0;
            for (int i = 0; i < SETTLE; i++) begin
                @(negedge clk);
                n_checks++;
                if (dut.deb_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_w%0d_deb: deb_a=%b, required 0", w, dut.deb_a);
                end
            end
        end
        n_checks++;
        if (frequency !== f0) begin
            n_fail++;
            $display("FAIL glitch_freq: freq=%0d, required %0d", frequency, f0);
        end
    endtask

    task automatic test_reverse_and_illegal();
        // Half turn then back.
        drive_phase(2'b01, 1'b0, 1'b1);
        drive_phase(2'b11, 1'b0, 1'b1);
        drive_phase(2'b01, 1'b0, 1'b0);
        drive_phase(2'b00, 1'b0, 1'b0);
        n_checks++;
        if (frequency !== model_freq) begin
            n_fail++;
            $display("FAIL reverse_freq: freq=%0d, required %0d", frequency, model_freq);
        end
        // 00 -> 11 -> 00 both illegal.
        drive_phase(2'b11, 1'b0, 1'b1);
        drive_phase(2'b00, 1'b0, 1'b1);
        // 01 then simultaneous toggle to 10 clears the accumulator.
        drive_phase(2'b01, 1'b0, 1'b1);
        drive_phase(2'b10, 1'b0, 1'b1);
        n_checks++;
        if (dut.acc_q !== 4'sd0) begin
            n_fail++;
            $display("FAIL illegal_acc: acc=%0d, required 0", dut.acc_q);
        end
        drive_phase(2'b00, 1'b0, 1'b1);
        n_checks++;
        if (frequency !== model_freq) begin
            n_fail++;
            $display("FAIL illegal_freq: freq=%0d, required %0d", frequency, model_freq);
        end
        cw_detent();
    endtask

    task automatic test_reset_mid_rotation();
        drive_phase(2'b01, 1'b0, 1'b1);
        drive_phase(2'b11, 1'b0, 1'b1);
        drive_phase(2'b10, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (frequency !== 2'b00 || step_cw !== 1'b0 || step_ccw !== 1'b0 || dut.acc_q !== 4'sd0) begin
            n_fail++;
            $display("FAIL mid_reset: freq=%0d cw=%b ccw=%b acc=%0d, required 0 0 0 0", frequency, step_cw, step_ccw, dut.acc_q);
        end
        model_freq = 2'b00;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (SETTLE) @(posedge clk);
        drive_phase(2'b00, 1'b0, 1'b1);
        cw_detent();
        n_checks++;
        if (frequency !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_reset_after: freq=%0d, required 1", frequency);
        end
    endtask

    task automatic test_cw_sequence();
        logic [1:0] req [5];
`ifdef ROTARY_WRAP_EN
        req = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
        req = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cw_detent();
            n_checks++;
            if (frequency !== req[k]) begin
                n_fail++;
                $display("FAIL cw_seq_%0d: freq=%0d, required %0d", k, frequency, req[k]);
            end
        end
    endtask

    task automatic test_ccw_at_zero();
        logic [1:0] req;
`ifdef ROTARY_WRAP_EN
        req = 2'd3;
`else
        req = 2'd0;
`endif
        do_reset();
        ccw_detent();
        n_checks++;
        if (frequency !== req) begin
            n_fail++;
            $display("FAIL ccw_zero: freq=%0d, required %0d", frequency, req);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        enc_a      = 1'b0;
        enc_b      = 1'b0;
        model_freq = 2'b00;
        prev_freq  = 2'b00;
        prev_rst_n = 1'b0;

        test_reset();
        test_single_cw();
        test_glitch();
        test_reverse_and_illegal();
        test_reset_mid_rotation();
        test_cw_sequence();
        test_ccw_at_zero();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
